// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory request/acknowledge bus between MEM stage and dmem
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: redirect, aligned dmem handshake, MEM/WB capture
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               beq_flag,
  input  logic               bgt_flag,
  input  logic               bge_flag,
  input  logic               blt_flag,
  input  logic               ble_flag,
  input  logic               bne_flag,
  input  logic               branch,
  input  logic               jump,
  input  logic [31:0]        branch_target,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        read_data_2,
  input  logic [2:0]         mem_type,
  input  logic [4:0]         write_reg,
  input  logic               mem_to_reg,
  input  logic               reg_write,
  input  logic               mem_read,
  input  logic               mem_write,
  mem_access_stage_if.master dmem,
  output logic               hit,
  output logic               pc_redirect,
  output logic [31:0]        pc_target,
  output logic               mem_err,
  output logic [31:0]        wb_data_out,
  output logic [31:0]        alu_result_out,
  output logic [4:0]         write_reg_out,
  output logic               mem_to_reg_out,
  output logic               reg_write_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        timed_out_q, timed_out_d;
  logic [31:0] load_q, load_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic        reg_write_q, reg_write_d;

  logic        is_half, is_byte, is_signed, aligned;
  logic [1:0]  lane;
  logic [3:0]  be;
  logic [31:0] wdata, load_val;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        access, req_c, hit_c, err_c;

  // Decode access size into lane enables, replicated store data and extended load data.
  always_comb begin
    is_half   = (mem_type == 3'd1) || (mem_type == 3'd2);
    is_byte   = (mem_type == 3'd3) || (mem_type == 3'd4);
    is_signed = (mem_type == 3'd1) || (mem_type == 3'd3);
    lane      = alu_result[1:0];
    if (is_byte) begin
      aligned = 1'b1;
      be      = 4'b0001 << lane;
      wdata   = {4{read_data_2[7:0]}};
    end else if (is_half) begin
      aligned = ~lane[0];
      be      = 4'b0011 << lane;
      wdata   = {2{read_data_2[15:0]}};
    end else begin
      aligned = (lane == 2'd0);
      be      = 4'b1111;
      wdata   = read_data_2;
    end
    byte_sel = dmem.dmem_rdata[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    if (is_byte) begin
      load_val = {{24{is_signed & byte_sel[7]}}, byte_sel};
    end else if (is_half) begin
      load_val = {{16{is_signed & half_sel[15]}}, half_sel};
    end else begin
      load_val = dmem.dmem_rdata;
    end
  end

  // Handshake sequencing, hit/error generation and hit-gated MEM/WB capture.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    timed_out_d  = timed_out_q;
    load_d       = load_q;
    wb_data_d    = wb_data_q;
    alu_result_d = alu_result_q;
    write_reg_d  = write_reg_q;
    mem_to_reg_d = mem_to_reg_q;
    reg_write_d  = reg_write_q;
    req_c        = 1'b0;
    hit_c        = 1'b1;
    err_c        = 1'b0;
    // A held reset must not launch a new access from the still-valid upstream inputs.
    access       = (mem_read | mem_write) & ~reset;

    case (state_q)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            req_c       = 1'b1;
            hit_c       = 1'b0;
            cnt_d       = 10'd0;
            timed_out_d = 1'b0;
            state_d     = ACCESS;
          end else begin
            err_c = 1'b1;
          end
        end
      end
      ACCESS: begin
        req_c = 1'b1;
        hit_c = 1'b0;
        // Ack is tested first so an ack on the final allowed cycle still completes cleanly.
        if (dmem.dmem_ack) begin
          load_d      = mem_write ? 32'd0 : load_val;
          timed_out_d = 1'b0;
          state_d     = DONE;
        end else if (cnt_q == CNT_LAST) begin
          load_d      = 32'd0;
          timed_out_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      DONE: begin
        err_c   = timed_out_q & ~reset;
        cnt_d   = 10'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (hit_c) begin
      alu_result_d = alu_result;
      write_reg_d  = write_reg;
      mem_to_reg_d = mem_to_reg;
      reg_write_d  = reg_write & ~err_c;
      wb_data_d    = (state_q == DONE) ? load_q : 32'd0;
    end
  end

  // State and pipeline register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 10'd0;
      timed_out_q  <= 1'b0;
      load_q       <= 32'd0;
      wb_data_q    <= 32'd0;
      alu_result_q <= 32'd0;
      write_reg_q  <= 5'd0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      timed_out_q  <= timed_out_d;
      load_q       <= load_d;
      wb_data_q    <= wb_data_d;
      alu_result_q <= alu_result_d;
      write_reg_q  <= write_reg_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
    end
  end

  assign pc_redirect = (branch & (beq_flag | bgt_flag | bge_flag | blt_flag | ble_flag | bne_flag)) | jump;
  assign pc_target   = branch_target;

  assign dmem.dmem_req   = req_c;
  assign dmem.dmem_we    = mem_write;
  assign dmem.dmem_addr  = {alu_result[31:2], 2'b00};
  assign dmem.dmem_wdata = wdata;
  assign dmem.dmem_be    = be;

  assign hit            = hit_c;
  assign mem_err        = err_c;
  assign wb_data_out    = wb_data_q;
  assign alu_result_out = alu_result_q;
  assign write_reg_out  = write_reg_q;
  assign mem_to_reg_out = mem_to_reg_q;
  assign reg_write_out  = reg_write_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage with random instructions
module tb_mem_access_stage;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        beq_flag = 0, bgt_flag = 0, bge_flag = 0, blt_flag = 0, ble_flag = 0, bne_flag = 0;
  logic        branch = 0, jump = 0;
  logic [31:0] branch_target = 0, alu_result = 0, read_data_2 = 0;
  logic [2:0]  mem_type = 0;
  logic [4:0]  write_reg = 0;
  logic        mem_to_reg = 0, reg_write = 0, mem_read = 0, mem_write = 0;
  logic        hit, pc_redirect, mem_err, mem_to_reg_out, reg_write_out;
  logic [31:0] pc_target, wb_data_out, alu_result_out;
  logic [4:0]  write_reg_out;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .beq_flag(beq_flag), .bgt_flag(bgt_flag), .bge_flag(bge_flag),
    .blt_flag(blt_flag), .ble_flag(ble_flag), .bne_flag(bne_flag),
    .branch(branch), .jump(jump), .branch_target(branch_target),
    .alu_result(alu_result), .read_data_2(read_data_2), .mem_type(mem_type),
    .write_reg(write_reg), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .dmem(bus.master),
    .hit(hit), .pc_redirect(pc_redirect), .pc_target(pc_target), .mem_err(mem_err),
    .wb_data_out(wb_data_out), .alu_result_out(alu_result_out),
    .write_reg_out(write_reg_out), .mem_to_reg_out(mem_to_reg_out),
    .reg_write_out(reg_write_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr, rd2, rdata, target;
    logic [2:0]  typ;
    logic        rd, wr, rw, m2r, branch, jump;
    logic [5:0]  flags;
    logic [4:0]  wreg;
    int          d;
  } instr_t;

  typedef struct {
    logic [31:0] be, addr, wdata, wb, target, alu;
    logic        we, err, rw, m2r, redir;
    logic [4:0]  wreg;
    int          low;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  bit   mon_en = 0;
  bit   stop_req = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Reference: derived from size/offset arithmetic, not from the RTL decode.
  function automatic exp_t model(instr_t i);
    exp_t   e;
    int     size, lane, dmin;
    bit     acc, ok;
    longint v;
    size = (i.typ == 1 || i.typ == 2) ? 2 : (i.typ == 3 || i.typ == 4) ? 1 : 4;
    lane = int'(i.addr % 4);
    acc  = i.rd | i.wr;
    ok   = (i.addr % size) == 0;
    dmin = (i.d < T) ? i.d : T;
    e.be    = 32'(((1 << size) - 1) << lane);
    e.addr  = i.addr - (i.addr % 4);
    e.wdata = (size == 4) ? i.rd2 : (size == 2) ? (i.rd2 & 32'hFFFF) * 32'h00010001
                                                : (i.rd2 & 32'hFF) * 32'h01010101;
    e.we    = i.wr;
    e.err   = acc && (!ok || i.d > T);
    e.low   = (acc && ok) ? 1 + dmin : 0;
    e.rw    = i.rw && !e.err;
    e.m2r   = i.m2r;
    e.wreg  = i.wreg;
    e.alu   = i.addr;
    e.redir = (i.branch && (i.flags != 0)) || i.jump;
    e.target = i.target;
    e.wb    = 32'd0;
    if (acc && ok && !e.err && i.rd && !i.wr) begin
      v = (longint'(i.rdata) >> (8 * lane)) & ((64'd1 << (8 * size)) - 1);
      if ((i.typ == 1 || i.typ == 3) && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
      e.wb = v[31:0];
    end
    return e;
  endfunction

  task automatic apply(instr_t i);
    {beq_flag, bgt_flag, bge_flag, blt_flag, ble_flag, bne_flag} = i.flags;
    branch = i.branch; jump = i.jump; branch_target = i.target;
    alu_result = i.addr; read_data_2 = i.rd2; mem_type = i.typ; write_reg = i.wreg;
    mem_to_reg = i.m2r; reg_write = i.rw; mem_read = i.rd; mem_write = i.wr;
    bus.dmem_rdata = i.rdata;
  endtask

  function automatic instr_t blank();
    instr_t i;
    i.addr = 0; i.rd2 = 0; i.rdata = 0; i.target = 0; i.typ = 0;
    i.rd = 0; i.wr = 0; i.rw = 0; i.m2r = 0; i.branch = 0; i.jump = 0;
    i.flags = 0; i.wreg = 0; i.d = 1;
    return i;
  endfunction

  // Drive one instruction, act as the memory responder, return just after its capture edge.
  task automatic run_instr(instr_t i);
    int  k;
    bit  done;
    sb.push_back(model(i));
    apply(i);
    bus.dmem_ack = 1'($urandom_range(0, 1));
    k = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if (hit) done = 1;
      @(posedge clk);
      #1;
      k++;
      bus.dmem_ack = done ? 1'b0 : (k == i.d);
      if (k > 200) begin
        $display("FAIL hit_wait: got no hit within %0d cycles expected hit", k);
        $fatal(1, "hit never returned");
      end
    end
  endtask

  // Monitor: checks bus while stalled, retire-cycle flags, then registered outputs one edge later.
  initial begin : monitor
    exp_t cur;
    bit   pend = 0;
    int   low_cnt = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (pend) begin
          chk("wb_data_out", wb_data_out, cur.wb);
          chk("reg_write_out", 32'(reg_write_out), 32'(cur.rw));
          chk("alu_result_out", alu_result_out, cur.alu);
          chk("write_reg_out", 32'(write_reg_out), 32'(cur.wreg));
          chk("mem_to_reg_out", 32'(mem_to_reg_out), 32'(cur.m2r));
          pend = 0;
        end
        if (stop_req) begin
          mon_en = 0;
        end else if (hit) begin
          if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
          end else begin
            cur = sb.pop_front();
            chk("mem_err", 32'(mem_err), 32'(cur.err));
            chk("hit_low_cycles", 32'(low_cnt), 32'(cur.low));
            chk("pc_redirect", 32'(pc_redirect), 32'(cur.redir));
            chk("pc_target", pc_target, cur.target);
            pend = 1;
          end
          low_cnt = 0;
        end else begin
          low_cnt++;
          chk("dmem_req", 32'(bus.dmem_req), 32'd1);
          chk("mem_err_stall", 32'(mem_err), 32'd0);
          if (sb.size() != 0) begin
            chk("dmem_be", 32'(bus.dmem_be), sb[0].be);
            chk("dmem_addr", bus.dmem_addr, sb[0].addr);
            chk("dmem_we", 32'(bus.dmem_we), 32'(sb[0].we));
            if (sb[0].we) chk("dmem_wdata", bus.dmem_wdata, sb[0].wdata);
          end
        end
      end
    end
  end

  initial begin : stim
    instr_t i;
    int     r;
    bus.dmem_ack = 0;
    bus.dmem_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(bus.dmem_req), 32'd0);
    chk("rst_hit", 32'(hit), 32'd1);
    chk("rst_err", 32'(mem_err), 32'd0);
    chk("rst_wb", wb_data_out, 32'd0);
    chk("rst_alu", alu_result_out, 32'd0);
    chk("rst_rw", 32'(reg_write_out), 32'd0);
    @(posedge clk);
    #1;
    reset = 0;
    mon_en = 1;

    i = blank(); i.rd = 1; i.rw = 1; i.m2r = 1; i.wreg = 5'd9; i.addr = 32'h100;
    i.rdata = 32'hDEADBEEF; i.d = 3;
    run_instr(i);
    i = blank(); i.rd = 1; i.rw = 1; i.addr = 32'h103; i.typ = 3; i.rdata = 32'h80112233; i.d = 1;
    run_instr(i);
    i.typ = 4;
    run_instr(i);
    i = blank(); i.wr = 1; i.addr = 32'h202; i.rd2 = 32'h0000ABCD; i.typ = 1; i.d = 1;
    run_instr(i);
    i = blank(); i.rd = 1; i.rw = 1; i.addr = 32'h101;
    run_instr(i);
    i = blank(); i.rd = 1; i.rw = 1; i.addr = 32'h40; i.rdata = 32'h12345678; i.d = 99;
    run_instr(i);
    i.d = T;
    run_instr(i);
    i = blank(); i.branch = 1; i.flags = 6'b000001; i.target = 32'h400; i.rw = 1;
    run_instr(i);

    for (int n = 0; n < 200; n++) begin
      i = blank();
      r = $urandom_range(0, 9);
      if (r < 4) i.rd = 1;
      else if (r < 7) i.wr = 1;
      i.typ = 3'($urandom_range(0, 7));
      i.addr = $urandom;
      i.rd2 = $urandom;
      i.rdata = $urandom;
      i.target = $urandom;
      i.rw = 1'($urandom_range(0, 1));
      i.m2r = 1'($urandom_range(0, 1));
      i.wreg = 5'($urandom_range(0, 31));
      i.flags = 6'($urandom_range(0, 63)) & ($urandom_range(0, 1) ? 6'h3F : 6'h00);
      i.branch = ($urandom_range(0, 2) == 0);
      i.jump = ($urandom_range(0, 4) == 0);
      i.d = $urandom_range(1, T + 2);
      run_instr(i);
    end

    stop_req = 1;
    apply(blank());
    @(negedge clk);
    #1;

    i = blank(); i.rd = 1; i.rw = 1; i.addr = 32'h300; i.wreg = 5'd3;
    apply(i);
    bus.dmem_ack = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_req", 32'(bus.dmem_req), 32'd0);
    chk("midrst_hit", 32'(hit), 32'd1);
    chk("midrst_err", 32'(mem_err), 32'd0);
    chk("midrst_wb", wb_data_out, 32'd0);
    chk("midrst_alu", alu_result_out, 32'd0);
    chk("midrst_rw", 32'(reg_write_out), 32'd0);
    @(posedge clk); #1;
    reset = 0;
    apply(blank());
    bus.dmem_rdata = 32'hCAFEF00D;
    bus.dmem_ack = 1;
    @(negedge clk);
    chk("late_ack_req", 32'(bus.dmem_req), 32'd0);
    chk("late_ack_err", 32'(mem_err), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("late_ack_wb", wb_data_out, 32'd0);
    chk("late_ack_rw", 32'(reg_write_out), 32'd0);
    chk("late_ack_hit", 32'(hit), 32'd1);
    bus.dmem_ack = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
